// File: rtl/button_event_gen.sv
// button_event_gen: debounced button levels to one-cycle press/repeat events plus a priority-encoded event bus.
module button_event_gen #(
    parameter int HOLD_CLOCKS   = 50_000_000,
    parameter int REPEAT_CLOCKS = 10_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       btnu_i,
    input  logic       btnd_i,
    input  logic       btnl_i,
    input  logic       btnr_i,
    input  logic       btnc_i,
    output logic       btnu_o,
    output logic       btnd_o,
    output logic       btnl_o,
    output logic       btnr_o,
    output logic       btnc_o,
    output logic       evt_valid_o,
    output logic [2:0] evt_code_o,
    output logic       evt_repeat_o
);
    localparam int MAXC = (HOLD_CLOCKS > REPEAT_CLOCKS) ? HOLD_CLOCKS : REPEAT_CLOCKS;
    localparam int CW = $clog2(MAXC);
    localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CLOCKS - 1);
    localparam logic [CW-1:0] REP_TC = CW'(REPEAT_CLOCKS - 1);

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    logic [4:0] lvl, pulse_d, pulse_q, rep_d, rep_q;
    logic       evt_valid_d, evt_valid_q, evt_repeat_d, evt_repeat_q;
    logic [2:0] evt_code_d, evt_code_q;

    // channel index: 0=U 1=D 2=L 3=R 4=C
    assign lvl = {btnc_i, btnr_i, btnl_i, btnd_i, btnu_i};

    for (genvar g = 0; g < 5; g++) begin : g_ch
        state_t        state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          p_d, r_d;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q    <= IDLE;
                cnt_q      <= '0;
                pulse_q[g] <= 1'b0;
                rep_q[g]   <= 1'b0;
            end else begin
                state_q    <= state_d;
                cnt_q      <= cnt_d;
                pulse_q[g] <= p_d;
                rep_q[g]   <= r_d;
            end
        end
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            p_d     = 1'b0;
            r_d     = rep_q[g];
            if (!lvl[g]) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        p_d     = 1'b1;
                        r_d     = 1'b0;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end
                    HOLD: begin
                        p_d     = (cnt_q == HOLD_TC);
                        r_d     = (cnt_q == HOLD_TC) | rep_q[g];
                        cnt_d   = (cnt_q == HOLD_TC) ? '0 : cnt_q + 1'b1;
                        state_d = (cnt_q == HOLD_TC) ? REPEAT : HOLD;
                    end
                    REPEAT: begin
                        p_d   = (cnt_q == REP_TC);
                        r_d   = (cnt_q == REP_TC) | rep_q[g];
                        cnt_d = (cnt_q == REP_TC) ? '0 : cnt_q + 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
        assign pulse_d[g] = p_d;
        assign rep_d[g]   = r_d;
    end

    // bus priority C > U > D > L > R, fed from next-state pulses to stay aligned with btnX_o
    always_comb begin
        evt_valid_d  = |pulse_d;
        evt_code_d   = pulse_d[4] ? 3'd5 : pulse_d[0] ? 3'd1 : pulse_d[1] ? 3'd2 :
                       pulse_d[2] ? 3'd3 : pulse_d[3] ? 3'd4 : 3'd0;
        evt_repeat_d = pulse_d[4] ? rep_d[4] : pulse_d[0] ? rep_d[0] : pulse_d[1] ? rep_d[1] :
                       pulse_d[2] ? rep_d[2] : pulse_d[3] ? rep_d[3] : 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            evt_valid_q  <= 1'b0;
            evt_code_q   <= 3'd0;
            evt_repeat_q <= 1'b0;
        end else begin
            evt_valid_q  <= evt_valid_d;
            evt_code_q   <= evt_code_d;
            evt_repeat_q <= evt_repeat_d;
        end
    end

    assign {btnc_o, btnr_o, btnl_o, btnd_o, btnu_o} = pulse_q;
    assign evt_valid_o  = evt_valid_q;
    assign evt_code_o   = evt_code_q;
    assign evt_repeat_o = evt_repeat_q;
endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen: directed checks of press, hold-repeat, priority and reset behaviour.
module tb_button_event_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btnu = 1'b0, btnd = 1'b0, btnl = 1'b0, btnr = 1'b0, btnc = 1'b0;
    logic       ou, od, ol, orr, oc, valid, rep;
    logic [2:0] code;
    int         checks = 0;
    int         failures = 0;

    button_event_gen #(.HOLD_CLOCKS(8), .REPEAT_CLOCKS(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .btnu_i(btnu), .btnd_i(btnd), .btnl_i(btnl), .btnr_i(btnr), .btnc_i(btnc),
        .btnu_o(ou), .btnd_o(od), .btnl_o(ol), .btnr_o(orr), .btnc_o(oc),
        .evt_valid_o(valid), .evt_code_o(code), .evt_repeat_o(rep)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // btn_exp bit order {C,R,L,D,U}
    task automatic chk(input string tag, input logic [4:0] btn_exp, input logic v_exp,
                       input logic [2:0] c_exp, input logic r_exp);
        logic [9:0] obs, exp_v;
        obs   = {oc, orr, ol, od, ou, valid, code, rep};
        exp_v = {btn_exp, v_exp, c_exp, r_exp};
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    initial begin
        #3 rst = 1'b1;
        #1 chk("reset_async", 5'b0, 1'b0, 3'd0, 1'b0);
        step();
        step();
        chk("reset_held", 5'b0, 1'b0, 3'd0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("post_reset_quiet", 5'b0, 1'b0, 3'd0, 1'b0);
        end

        btnu = 1'b1;
        step();
        chk("short_press", 5'b00001, 1'b1, 3'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("short_hold_quiet", 5'b0, 1'b0, 3'd0, 1'b0);
        end
        btnu = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("short_release_quiet", 5'b0, 1'b0, 3'd0, 1'b0);
        end

        btnl = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            step();
            if (t == 1 || (t >= 9 && (t - 9) % 4 == 0))
                chk("long_hold_pulse", 5'b00100, 1'b1, 3'd3, t != 1);
            else
                chk("long_hold_quiet", 5'b0, 1'b0, 3'd0, 1'b0);
        end
        btnl = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("long_release_quiet", 5'b0, 1'b0, 3'd0, 1'b0);
        end

        btnc = 1'b1;
        btnr = 1'b1;
        step();
        chk("simul_c_r", 5'b11000, 1'b1, 3'd5, 1'b0);
        btnc = 1'b0;
        btnr = 1'b0;
        step();
        chk("simul_release", 5'b0, 1'b0, 3'd0, 1'b0);

        btnr = 1'b1;
        step();
        chk("glitch_press", 5'b01000, 1'b1, 3'd4, 1'b0);
        btnr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("glitch_quiet", 5'b0, 1'b0, 3'd0, 1'b0);
        end

        btnd = 1'b1;
        step();
        chk("tc_press", 5'b00010, 1'b1, 3'd2, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("tc_hold_quiet", 5'b0, 1'b0, 3'd0, 1'b0);
        end
        btnd = 1'b0;
        step();
        chk("tc_release_no_repeat", 5'b0, 1'b0, 3'd0, 1'b0);
        step();
        chk("tc_idle_gap", 5'b0, 1'b0, 3'd0, 1'b0);
        btnd = 1'b1;
        step();
        chk("tc_repress", 5'b00010, 1'b1, 3'd2, 1'b0);
        btnd = 1'b0;
        step();
        chk("tc_repress_release", 5'b0, 1'b0, 3'd0, 1'b0);

        btnc = 1'b1;
        step();
        chk("rmid_press", 5'b10000, 1'b1, 3'd5, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rmid_hold_quiet", 5'b0, 1'b0, 3'd0, 1'b0);
        end
        #2 rst = 1'b1;
        #1 chk("rmid_async", 5'b0, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rmid_in_reset", 5'b0, 1'b0, 3'd0, 1'b0);
        end
        rst = 1'b0;
        step();
        chk("rmid_new_press", 5'b10000, 1'b1, 3'd5, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("rmid_wait_quiet", 5'b0, 1'b0, 3'd0, 1'b0);
        end
        step();
        chk("rmid_first_repeat", 5'b10000, 1'b1, 3'd5, 1'b1);
        btnc = 1'b0;
        step();
        chk("rmid_release", 5'b0, 1'b0, 3'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
